bin_demux_dispatch: RTL and testbench
=====================================

Name: bin_demux_dispatch

Overview:
Single-source to NUM_SINKS-sink dispatcher for the interconnect. It accepts a binary sink index plus a data word over a valid/ready handshake and decodes the index to a one-hot valid toward the addressed sink. It is the decode-side counterpart of the sink-select priority encoder. A 2-entry buffer gives full throughput and decouples the source from sink backpressure.

Parameters:
NUM_SINKS, 64, number of sink ports (any value 2..2^LOG2_NUM_SINKS)
LOG2_NUM_SINKS, 6, width of the binary index; must satisfy 2^LOG2_NUM_SINKS >= NUM_SINKS
DATA_WIDTH, 32, payload width

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  source presents in_idx/in_data
in_ready  output  1  block can accept this cycle
in_idx  input  LOG2_NUM_SINKS  destination sink index (binary)
in_data  input  DATA_WIDTH  payload
out_valids  output  NUM_SINKS  one-hot (or zero) valid per sink
out_readys  input  NUM_SINKS  per-sink ready
out_data  output  DATA_WIDTH  payload of the head entry, shared by all sinks
out_idx  output  LOG2_NUM_SINKS  binary index of the head entry
err_idx  output  1  one-cycle pulse: an out-of-range index was dropped
drop_count  output  8  saturating count of dropped transfers

Behaviour:
- Reset (rst_n=0 at a clock edge): occupancy=0, out_valids=0, out_data=0, out_idx=0, err_idx=0, drop_count=0. Reset mid-operation discards all buffered entries with no partial delivery. in_ready is 0 during reset.
- Storage: 2-entry FIFO (head, tail) of {idx, data}, with occupancy counter 0..2.
- in_ready = (occupancy < 2), taken from registered state only. No combinational path from out_readys to in_ready.
- Accept: in_valid & in_ready at a clock edge.
- Accepted entry with in_idx < NUM_SINKS: written to the FIFO.
- Accepted entry with in_idx >= NUM_SINKS: not stored. err_idx=1 on the next cycle only. drop_count increments by 1 and saturates at 255.
- Head presentation: when occupancy>0, out_valids = one-hot decode of the head idx, out_idx = head idx, out_data = head data. When occupancy=0, out_valids=0. out_data and out_idx hold their last value.
- Pop: out_valids[out_idx] & out_readys[out_idx] at a clock edge. out_readys bits of non-addressed sinks are ignored.
- Latency: an entry accepted into an empty FIFO appears on out_valids in the next cycle. Minimum 1-cycle latency; no bypass.
- Simultaneous accept and pop at occupancy=1: the head is replaced by the new entry and occupancy stays 1. This sustains 1 transfer/cycle.
- Simultaneous accept and pop at occupancy=2: cannot occur because in_ready=0.
- Pop at occupancy=2: the tail moves to the head and occupancy becomes 1. in_ready=1 in the next cycle.
- An accepted out-of-range entry coinciding with a pop: the pop proceeds and occupancy decrements.
- Order: entries are delivered strictly in acceptance order, with no reordering across sinks. A stalled head blocks later entries for other sinks (head-of-line blocking is intended).
- Stability: while the head is valid and not popped, out_valids, out_idx and out_data are held constant.
- Invariant: popcount(out_valids) <= 1 on every cycle.

Test Plan:
- Reset, then in_valid=0 for 5 cycles -> out_valids=0, in_ready=1 from the first post-reset cycle, drop_count=0.
- Push idx=5, data=0xA5A5_0001 with out_readys all 1 -> next cycle out_valids=64'h20 and out_data=0xA5A5_0001 for exactly 1 cycle, then 0.
- Stream of 8 back-to-back pushes, idx=0..7, with out_readys all 1 -> in_ready stays 1 and out_valids walks 1,2,4,...,0x80 on consecutive cycles, with no bubbles.
- out_readys=0, then push idx 3, 9, 12 -> the first two are accepted and in_ready drops after the second. out_valids holds 64'h8 and data holds steady. Raise out_readys[3] for 1 cycle -> idx 9 becomes head and the third push is accepted.
- With NUM_SINKS=48, push idx=50 -> never appears on out_valids, err_idx pulses once, drop_count=1. Then push 300 out-of-range entries -> drop_count=255.
- Assert rst_n=0 for 1 cycle with 2 entries buffered -> out_valids=0 and occupancy=0 next cycle, and no stale entry is delivered after reset.

Source files
------------

// File: rtl/bin_demux_dispatch.sv
// Binary-index dispatcher: a 2-entry FIFO of {idx, data} whose head is decoded
// to a one-hot valid toward the addressed sink. Out-of-range indices are dropped and counted.
module bin_demux_dispatch #(
    parameter int unsigned NUM_SINKS      = 64,
    parameter int unsigned LOG2_NUM_SINKS = 6,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LOG2_NUM_SINKS-1:0] in_idx,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic [NUM_SINKS-1:0]      out_valids,
    input  logic [NUM_SINKS-1:0]      out_readys,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [LOG2_NUM_SINKS-1:0] out_idx,
    output logic                      err_idx,
    output logic [7:0]                drop_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam logic [LOG2_NUM_SINKS:0] IDX_LIMIT = (LOG2_NUM_SINKS + 1)'(NUM_SINKS);

    occ_t                      state_q, state_d;
    logic [LOG2_NUM_SINKS-1:0] head_idx_q, head_idx_d, tail_idx_q, tail_idx_d;
    logic [DATA_WIDTH-1:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic                      in_ready_q;
    logic                      err_q;
    logic [7:0]                drop_q;

    logic accept, in_range, push, pop, head_valid;

    assign accept     = in_valid & in_ready_q;
    assign in_range   = {1'b0, in_idx} < IDX_LIMIT;
    assign push       = accept & in_range;
    assign head_valid = (state_q != OCC_EMPTY);
    assign pop        = |(out_valids & out_readys);

    always_comb begin
        out_valids = '0;
        for (int unsigned i = 0; i < NUM_SINKS; i++) begin
            out_valids[i] = head_valid && (head_idx_q == i[LOG2_NUM_SINKS-1:0]);
        end
    end

    always_comb begin
        state_d     = state_q;
        head_idx_d  = head_idx_q;
        head_data_d = head_data_q;
        tail_idx_d  = tail_idx_q;
        tail_data_d = tail_data_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_idx_d  = in_idx;
                    head_data_d = in_data;
                    state_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                // Push with pop replaces the head in place to sustain one transfer per cycle.
                if (push && pop) begin
                    head_idx_d  = in_idx;
                    head_data_d = in_data;
                end else if (push) begin
                    tail_idx_d  = in_idx;
                    tail_data_d = in_data;
                    state_d     = OCC_FULL;
                end else if (pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_idx_d  = tail_idx_q;
                    head_data_d = tail_data_q;
                    state_d     = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            head_idx_q  <= '0;
            head_data_q <= '0;
            tail_idx_q  <= '0;
            tail_data_q <= '0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            head_idx_q  <= head_idx_d;
            head_data_q <= head_data_d;
            tail_idx_q  <= tail_idx_d;
            tail_data_q <= tail_data_d;
            // Registered from next occupancy so out_readys never reaches in_ready combinationally.
            in_ready_q  <= (state_d != OCC_FULL);
            err_q       <= accept & ~in_range;
            if (accept && !in_range && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_data   = head_data_q;
    assign out_idx    = head_idx_q;
    assign err_idx    = err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_bin_demux_dispatch.sv
// Directed bench for bin_demux_dispatch: a default 64-sink instance and a
// 48-sink instance for out-of-range drop behaviour.
module tb_bin_demux_dispatch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        in_valid, in_ready, err_idx;
    logic [5:0]  in_idx, out_idx;
    logic [31:0] in_data, out_data;
    logic [63:0] out_valids, out_readys;
    logic [7:0]  drop_count;

    logic        in_valid48, in_ready48, err_idx48;
    logic [5:0]  in_idx48, out_idx48;
    logic [31:0] in_data48, out_data48;
    logic [47:0] out_valids48, out_readys48;
    logic [7:0]  drop_count48;

    bin_demux_dispatch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_data(in_data), .out_valids(out_valids),
        .out_readys(out_readys), .out_data(out_data), .out_idx(out_idx),
        .err_idx(err_idx), .drop_count(drop_count)
    );

    bin_demux_dispatch #(.NUM_SINKS(48), .LOG2_NUM_SINKS(6), .DATA_WIDTH(32)) dut48 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid48), .in_ready(in_ready48),
        .in_idx(in_idx48), .in_data(in_data48), .out_valids(out_valids48),
        .out_readys(out_readys48), .out_data(out_data48), .out_idx(out_idx48),
        .err_idx(err_idx48), .drop_count(drop_count48)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valids !== 64'h0) begin errors++; $display("FAIL rst_valids got %h exp 0", out_valids); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
        checks++; if (out_idx !== 6'h0) begin errors++; $display("FAIL rst_idx got %h exp 0", out_idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (err_idx !== 1'b0 || drop_count !== 8'h0) begin errors++; $display("FAIL rst_err got %b/%h exp 0/0", err_idx, drop_count); end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++; if (out_valids !== 64'h0) begin errors++; $display("FAIL idle_valids got %h exp 0", out_valids); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
        checks++; if (drop_count !== 8'h0) begin errors++; $display("FAIL idle_drop got %h exp 0", drop_count); end
    endtask

    task automatic test_single();
        out_readys = '1;
        in_valid = 1'b1; in_idx = 6'd5; in_data = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valids !== 64'h20) begin errors++; $display("FAIL single_valids got %h exp 20", out_valids); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got %h exp a5a50001", out_data); end
        checks++; if (out_idx !== 6'd5) begin errors++; $display("FAIL single_idx got %0d exp 5", out_idx); end
        tick();
        checks++; if (out_valids !== 64'h0) begin errors++; $display("FAIL single_pop got %h exp 0", out_valids); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_hold got %h exp a5a50001", out_data); end
        in_valid = 1'b1; in_idx = 6'd63; in_data = 32'h6363_6363;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valids !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL top_idx got %h exp 8000000000000000", out_valids); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        out_readys = '1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_idx = 6'(i);
            in_data = 32'hB000_0000 + 32'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
            tick();
            exp = 64'h1 << i;
            checks++; if (out_valids !== exp || out_data !== 32'hB000_0000 + 32'(i)) begin
                errors++; $display("FAIL b2b_walk[%0d] got %h/%h exp %h/%h", i, out_valids, out_data, exp, 32'hB000_0000 + 32'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valids !== 64'h0) begin errors++; $display("FAIL b2b_drain got %h exp 0", out_valids); end
    endtask

    task automatic test_backpressure();
        out_readys = '0;
        in_valid = 1'b1; in_idx = 6'd3; in_data = 32'hD003;
        tick();
        in_idx = 6'd9; in_data = 32'hD009;
        tick();
        in_idx = 6'd12; in_data = 32'hD00C;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        checks++; if (out_valids !== 64'h8 || out_data !== 32'hD003) begin errors++; $display("FAIL bp_head got %h/%h exp 8/d003", out_valids, out_data); end
        out_readys = ~(64'h1 << 3);
        tick();
        checks++; if (out_valids !== 64'h8 || out_data !== 32'hD003 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got %h/%h/%b exp 8/d003/0", out_valids, out_data, in_ready);
        end
        out_readys = 64'h1 << 3;
        tick();
        out_readys = '0;
        checks++; if (out_valids !== (64'h1 << 9) || out_data !== 32'hD009) begin errors++; $display("FAIL bp_advance got %h/%h exp 200/d009", out_valids, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valids !== (64'h1 << 9)) begin errors++; $display("FAIL bp_third got %b/%h exp 0/200", in_ready, out_valids); end
        out_readys = '1;
        tick();
        checks++; if (out_valids !== (64'h1 << 12) || out_data !== 32'hD00C) begin errors++; $display("FAIL bp_order got %h/%h exp 1000/d00c", out_valids, out_data); end
        tick();
        checks++; if (out_valids !== 64'h0) begin errors++; $display("FAIL bp_empty got %h exp 0", out_valids); end
    endtask

    task automatic test_out_of_range();
        out_readys48 = '1;
        in_valid48 = 1'b1; in_idx48 = 6'd50; in_data48 = 32'hEEEE_0050;
        tick();
        in_valid48 = 1'b0;
        checks++; if (err_idx48 !== 1'b1 || drop_count48 !== 8'd1) begin errors++; $display("FAIL oor_err got %b/%0d exp 1/1", err_idx48, drop_count48); end
        checks++; if (out_valids48 !== 48'h0) begin errors++; $display("FAIL oor_valids got %h exp 0", out_valids48); end
        tick();
        checks++; if (err_idx48 !== 1'b0 || out_valids48 !== 48'h0) begin errors++; $display("FAIL oor_pulse got %b/%h exp 0/0", err_idx48, out_valids48); end
        in_valid48 = 1'b1; in_idx48 = 6'd47; in_data48 = 32'h4747_4747;
        tick();
        in_valid48 = 1'b0;
        checks++; if (out_valids48 !== 48'h8000_0000_0000 || out_idx48 !== 6'd47) begin
            errors++; $display("FAIL edge47 got %h/%0d exp 800000000000/47", out_valids48, out_idx48);
        end
        checks++; if (err_idx48 !== 1'b0 || drop_count48 !== 8'd1) begin errors++; $display("FAIL edge47_err got %b/%0d exp 0/1", err_idx48, drop_count48); end
        tick();
        in_valid48 = 1'b1; in_idx48 = 6'd60;
        repeat (200) tick();
        checks++; if (drop_count48 !== 8'd201) begin errors++; $display("FAIL drop_mid got %0d exp 201", drop_count48); end
        repeat (100) tick();
        in_valid48 = 1'b0;
        checks++; if (drop_count48 !== 8'd255 || err_idx48 !== 1'b1) begin errors++; $display("FAIL drop_sat got %0d/%b exp 255/1", drop_count48, err_idx48); end
        tick();
        checks++; if (err_idx48 !== 1'b0 || out_valids48 !== 48'h0) begin errors++; $display("FAIL drop_end got %b/%h exp 0/0", err_idx48, out_valids48); end
    endtask

    task automatic test_reset_midop();
        out_readys = '0;
        in_valid = 1'b1; in_idx = 6'd1; in_data = 32'hC001;
        tick();
        in_idx = 6'd2; in_data = 32'hC002;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valids !== 64'h2 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_prefill got %h/%b exp 2/0", out_valids, in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_valids !== 64'h0 || out_data !== 32'h0 || drop_count48 !== 8'h0) begin
            errors++; $display("FAIL mid_reset got %h/%h/%0d exp 0/0/0", out_valids, out_data, drop_count48);
        end
        out_readys = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valids !== 64'h0) begin errors++; $display("FAIL mid_stale[%0d] got %h exp 0", i, out_valids); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_idx = '0; in_data = '0; out_readys = '0;
        in_valid48 = 1'b0; in_idx48 = '0; in_data48 = '0; out_readys48 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
